instr_fetch_unit: RTL

Fetch sequencer that acts as the reading (and program-loading) master of the 16x13 instruction SRAM. It loads a program word-by-word into the SRAM, then fetches instructions from address 0 with the SRAM's one-cycle registered read latency. It splits each instruction into the opcode and three 2-bit fields, presents it to the execute stage under a valid/stall handshake, and follows branch redirects from execute.

---
 rtl/instr_fetch_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch sequencer that owns the instruction SRAM. While idle it can load a
// program one word at a time; on start it fetches from address 0, waits out
// the SRAM's one-cycle registered read, splits the instruction into opcode and
// three 2-bit fields and holds it for the execute stage until accepted.
// Accepting a non-halt instruction follows either the sequential PC or a
// branch redirect; accepting the halt opcode pulses done and returns to idle.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        pulse: begin fetching at PC 0 (wins over load_valid)
//   load_valid   pulse: load_data is the next program word
//   load_data    program word to write at the load pointer
//   mem_wr       SRAM write enable
//   mem_a        SRAM address
//   mem_d        SRAM write data
//   mem_q        SRAM registered read data
//   stall        execute cannot accept the presented instruction
//   br_taken     redirect, sampled only on the accepting cycle
//   br_target    redirect address
//   instr_valid  opcode/field_*/pc_out hold a valid instruction
//   opcode       IR[12:6]
//   field_a      IR[5:4]
//   field_b      IR[3:2]
//   field_c      IR[1:0]
//   pc_out       address of the presented instruction
//   busy         sequencer is not idle
//   done         one-cycle pulse after the halt opcode is accepted
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned           ADDR_W  = 4,
    parameter int unsigned           INSTR_W = 13,
    parameter logic [INSTR_W-7:0]    HALT_OP = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 load_valid,
    input  logic [INSTR_W-1:0]   load_data,
    output logic                 mem_wr,
    output logic [ADDR_W-1:0]    mem_a,
    output logic [INSTR_W-1:0]   mem_d,
    input  logic [INSTR_W-1:0]   mem_q,
    input  logic                 stall,
    input  logic                 br_taken,
    input  logic [ADDR_W-1:0]    br_target,
    output logic                 instr_valid,
    output logic [INSTR_W-7:0]   opcode,
    output logic [1:0]           field_a,
    output logic [1:0]           field_b,
    output logic [1:0]           field_c,
    output logic [ADDR_W-1:0]    pc_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFetch,
        StWait,
        StIssue
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    lp_q, lp_d;
    logic                 mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]    mem_a_q, mem_a_d;
    logic [INSTR_W-1:0]   mem_d_q, mem_d_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [ADDR_W-1:0]    pc_out_q, pc_out_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [ADDR_W-1:0]    next_pc;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        lp_d     = lp_q;
        mem_wr_d = mem_wr_q;
        mem_a_d  = mem_a_q;
        mem_d_d  = mem_d_q;
        ir_d     = ir_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        next_pc  = br_taken ? br_target : pc_q + ADDR_W'(1);

        case (state_q)
            StIdle: begin
                if (start) begin
                    // A load word arriving together with start is dropped.
                    pc_d     = '0;
                    mem_a_d  = '0;
                    mem_wr_d = 1'b0;
                    state_d  = StFetch;
                end else if (load_valid) begin
                    mem_wr_d = 1'b1;
                    mem_a_d  = lp_q;
                    mem_d_d  = load_data;
                    lp_d     = lp_q + ADDR_W'(1);
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                // The SRAM takes the write at the end of this cycle; any
                // load_valid seen here is ignored.
                mem_wr_d = 1'b0;
                state_d  = StIdle;
            end
            StFetch: begin
                // mem_a already equals pc, set on entry.
                state_d = StWait;
            end
            StWait: begin
                ir_d     = mem_q;
                pc_out_d = pc_q;
                valid_d  = 1'b1;
                state_d  = StIssue;
            end
            StIssue: begin
                if (!stall) begin
                    valid_d = 1'b0;
                    if (ir_q[INSTR_W-1:6] == HALT_OP) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        pc_d    = next_pc;
                        mem_a_d = next_pc;
                        state_d = StFetch;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered so busy tracks the state register exactly.
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            lp_q     <= '0;
            mem_wr_q <= 1'b0;
            mem_a_q  <= '0;
            mem_d_q  <= '0;
            ir_q     <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            lp_q     <= lp_d;
            mem_wr_q <= mem_wr_d;
            mem_a_q  <= mem_a_d;
            mem_d_q  <= mem_d_d;
            ir_q     <= ir_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mem_wr      = mem_wr_q;
    assign mem_a       = mem_a_q;
    assign mem_d       = mem_d_q;
    assign instr_valid = valid_q;
    assign opcode      = ir_q[INSTR_W-1:6];
    assign field_a     = ir_q[5:4];
    assign field_b     = ir_q[3:2];
    assign field_c     = ir_q[1:0];
    assign pc_out      = pc_out_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
